// File: rtl/lsu_mmio_v2.sv
// rtl/lsu_mmio_v2.sv - load/store unit with data memory, board I/O registers and valid/ready handshake
module lsu_mmio_v2 #(
    parameter logic [31:0] DMEM_BASE  = 32'h0000_2000,
    parameter int          DMEM_DEPTH = 64,
    parameter int          LEDR_W     = 32,
    parameter int          LEDG_W     = 32,
    parameter int          SW_W       = 32,
    parameter int          BTN_W      = 4,
    parameter int          NUM_HEX    = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_req_vld,
    output logic                   o_req_rdy,
    input  logic [31:0]            i_req_addr,
    input  logic                   i_req_wren,
    input  logic [1:0]             i_req_size,
    input  logic                   i_req_unsigned,
    input  logic [31:0]            i_req_wdata,
    output logic                   o_rsp_vld,
    input  logic                   i_rsp_rdy,
    output logic [31:0]            o_rsp_rdata,
    output logic                   o_rsp_err,
    output logic                   o_lcd_vld,
    input  logic [SW_W-1:0]        i_io_sw,
    input  logic [BTN_W-1:0]       i_io_btn,
    output logic [LEDR_W-1:0]      o_io_ledr,
    output logic [LEDG_W-1:0]      o_io_ledg,
    output logic [31:0]            o_io_lcd,
    output logic [NUM_HEX*7-1:0]   o_io_hex
);
    localparam int AW = $clog2(DMEM_DEPTH);
    localparam logic [15:0] A_LEDR = 16'h7000;
    localparam logic [15:0] A_LEDG = 16'h7010;
    localparam logic [15:0] A_SEGL = 16'h7020;
    localparam logic [15:0] A_SEGH = 16'h7024;
    localparam logic [15:0] A_LCD  = 16'h7030;
    localparam logic [15:0] A_SW   = 16'h7800;
    localparam logic [15:0] A_BTN  = 16'h7810;
    localparam logic [15:0] A_BTNE = 16'h7814;

    typedef enum logic {IDLE, RESP} state_t;
    state_t state, state_nxt;

    logic        accept, wr_ok, req_err, misaligned, mapped, hi_zero;
    logic        sel_dmem, sel_ledr, sel_ledg, sel_segl, sel_segh, sel_lcd, sel_sw, sel_btn, sel_btne;
    logic [13:0] pw;
    logic [3:0]  lane_mask;
    logic [31:0] bit_mask, repl, rd_periph, merged;
    logic [55:0] hex_all, hex_nxt;

    logic [LEDR_W-1:0]    ledr_q;
    logic [LEDG_W-1:0]    ledg_q;
    logic [31:0]          lcd_q;
    logic [NUM_HEX*7-1:0] hex_q;
    logic                 lcd_vld_q;
    logic [BTN_W-1:0]     btn_s1, btn_s2, btn_prev, edge_q, btn_rise, btn_clr;

    logic [31:0] mem [DMEM_DEPTH];
    logic [31:0] dmem_rd;
    logic [AW-1:0] idx;

    logic        rsp_err_q, rsp_load_q, rsp_uns_q, rsp_dmem_q;
    logic [1:0]  rsp_size_q, rsp_off_q;
    logic [31:0] rsp_periph_q, rsp_word, rsp_sh;

    assign o_rsp_vld = (state == RESP);
    assign o_req_rdy = !o_rsp_vld || i_rsp_rdy;
    assign accept    = i_req_vld && o_req_rdy;

    assign hi_zero  = (i_req_addr[31:16] == 16'h0000);
    assign pw       = i_req_addr[15:2];
    assign sel_dmem = hi_zero && (i_req_addr[31:AW+2] == DMEM_BASE[31:AW+2]);
    assign sel_ledr = hi_zero && !sel_dmem && (pw == A_LEDR[15:2]);
    assign sel_ledg = hi_zero && !sel_dmem && (pw == A_LEDG[15:2]);
    assign sel_segl = hi_zero && !sel_dmem && (pw == A_SEGL[15:2]);
    assign sel_segh = hi_zero && !sel_dmem && (pw == A_SEGH[15:2]);
    assign sel_lcd  = hi_zero && !sel_dmem && (pw == A_LCD[15:2]);
    assign sel_sw   = hi_zero && !sel_dmem && (pw == A_SW[15:2]);
    assign sel_btn  = hi_zero && !sel_dmem && (pw == A_BTN[15:2]);
    assign sel_btne = hi_zero && !sel_dmem && (pw == A_BTNE[15:2]);
    assign mapped   = sel_dmem | sel_ledr | sel_ledg | sel_segl | sel_segh | sel_lcd
                    | sel_sw | sel_btn | sel_btne;

    always_comb begin
        misaligned = 1'b0;
        lane_mask  = 4'b0000;
        repl       = i_req_wdata;
        case (i_req_size)
            2'b00: begin
                lane_mask = 4'b0001 << i_req_addr[1:0];
                repl      = {4{i_req_wdata[7:0]}};
            end
            2'b01: begin
                misaligned = i_req_addr[0];
                lane_mask  = i_req_addr[1] ? 4'b1100 : 4'b0011;
                repl       = {2{i_req_wdata[15:0]}};
            end
            2'b10: begin
                misaligned = (i_req_addr[1:0] != 2'b00);
                lane_mask  = 4'b1111;
            end
            default: misaligned = 1'b1;
        endcase
    end

    assign bit_mask = {{8{lane_mask[3]}}, {8{lane_mask[2]}}, {8{lane_mask[1]}}, {8{lane_mask[0]}}};
    assign req_err  = misaligned || !mapped || (i_req_wren && (sel_sw || sel_btn));
    assign wr_ok    = accept && i_req_wren && !req_err;
    assign idx      = i_req_addr[AW+1:2];

    // Peripheral read word, zero-padded; also the merge base for stores
    always_comb begin
        hex_all = '0;
        hex_all[NUM_HEX*7-1:0] = hex_q;
        rd_periph = '0;
        if (sel_ledr) rd_periph[LEDR_W-1:0] = ledr_q;
        if (sel_ledg) rd_periph[LEDG_W-1:0] = ledg_q;
        if (sel_lcd)  rd_periph = lcd_q;
        if (sel_sw)   rd_periph[SW_W-1:0] = i_io_sw;
        if (sel_btn)  rd_periph[BTN_W-1:0] = btn_s2;
        if (sel_btne) rd_periph[BTN_W-1:0] = edge_q;
        for (int k = 0; k < 4; k++) begin
            if (sel_segl) rd_periph[8*k +: 7] = hex_all[7*k +: 7];
            if (sel_segh) rd_periph[8*k +: 7] = hex_all[7*(k+4) +: 7];
        end
    end

    assign merged = (rd_periph & ~bit_mask) | (repl & bit_mask);

    always_comb begin
        hex_nxt = hex_all;
        for (int k = 0; k < 4; k++) begin
            if (sel_segl) hex_nxt[7*k +: 7]     = merged[8*k +: 7];
            if (sel_segh) hex_nxt[7*(k+4) +: 7] = merged[8*k +: 7];
        end
    end

    assign btn_rise = btn_s2 & ~btn_prev;
    assign btn_clr  = (wr_ok && sel_btne) ? (repl[BTN_W-1:0] & bit_mask[BTN_W-1:0]) : '0;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ledr_q    <= '0;
            ledg_q    <= '0;
            lcd_q     <= '0;
            hex_q     <= '0;
            lcd_vld_q <= 1'b0;
            btn_s1    <= '0;
            btn_s2    <= '0;
            btn_prev  <= '0;
            edge_q    <= '0;
        end else begin
            lcd_vld_q <= wr_ok && sel_lcd;
            if (wr_ok && sel_ledr) ledr_q <= merged[LEDR_W-1:0];
            if (wr_ok && sel_ledg) ledg_q <= merged[LEDG_W-1:0];
            if (wr_ok && sel_lcd)  lcd_q  <= merged;
            if (wr_ok && (sel_segl || sel_segh)) hex_q <= hex_nxt[NUM_HEX*7-1:0];
            btn_s1   <= i_io_btn;
            btn_s2   <= btn_s1;
            btn_prev <= btn_s2;
            // set has priority over a same-cycle clear
            edge_q   <= (edge_q & ~btn_clr) | btn_rise;
        end
    end

    // Data memory: no reset so it maps onto block RAM with byte enables
    always_ff @(posedge i_clk) begin
        if (accept) begin
            if (wr_ok && sel_dmem) begin
                for (int k = 0; k < 4; k++) begin
                    if (lane_mask[k]) mem[idx][8*k +: 8] <= repl[8*k +: 8];
                end
            end
            dmem_rd <= mem[idx];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rsp_err_q    <= 1'b0;
            rsp_load_q   <= 1'b0;
            rsp_uns_q    <= 1'b0;
            rsp_dmem_q   <= 1'b0;
            rsp_size_q   <= 2'b00;
            rsp_off_q    <= 2'b00;
            rsp_periph_q <= '0;
        end else if (accept) begin
            rsp_err_q    <= req_err;
            rsp_load_q   <= !i_req_wren;
            rsp_uns_q    <= i_req_unsigned;
            rsp_dmem_q   <= sel_dmem;
            rsp_size_q   <= i_req_size;
            rsp_off_q    <= i_req_addr[1:0];
            rsp_periph_q <= rd_periph;
        end
    end

    assign rsp_word = rsp_dmem_q ? dmem_rd : rsp_periph_q;
    assign rsp_sh   = rsp_word >> {rsp_off_q, 3'b000};

    always_comb begin
        o_rsp_rdata = '0;
        if (o_rsp_vld && rsp_load_q && !rsp_err_q) begin
            case (rsp_size_q)
                2'b00:   o_rsp_rdata = rsp_uns_q ? {24'h0, rsp_sh[7:0]}
                                                 : {{24{rsp_sh[7]}}, rsp_sh[7:0]};
                2'b01:   o_rsp_rdata = rsp_uns_q ? {16'h0, rsp_sh[15:0]}
                                                 : {{16{rsp_sh[15]}}, rsp_sh[15:0]};
                default: o_rsp_rdata = rsp_sh;
            endcase
        end
    end
    assign o_rsp_err = o_rsp_vld && rsp_err_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RESP;
            RESP:    if (!accept && i_rsp_rdy) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign o_lcd_vld = lcd_vld_q;
    assign o_io_ledr = ledr_q;
    assign o_io_ledg = ledg_q;
    assign o_io_lcd  = lcd_q;
    assign o_io_hex  = hex_q;
endmodule

// File: tb/tb_lsu_mmio_v2.sv
// tb/tb_lsu_mmio_v2.sv - self-checking bench for lsu_mmio_v2 with a byte-addressed reference model
module tb_lsu_mmio_v2;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_vld, req_rdy, req_wren, req_uns, rsp_vld, rsp_rdy, rsp_err, lcd_vld;
    logic [31:0] req_addr, req_wdata, rsp_rdata, io_sw, io_ledr, io_ledg, io_lcd;
    logic [1:0]  req_size;
    logic [3:0]  io_btn;
    logic [55:0] io_hex;

    int checks = 0;
    int failures = 0;

    lsu_mmio_v2 dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_vld(req_vld), .o_req_rdy(req_rdy), .i_req_addr(req_addr),
        .i_req_wren(req_wren), .i_req_size(req_size), .i_req_unsigned(req_uns),
        .i_req_wdata(req_wdata), .o_rsp_vld(rsp_vld), .i_rsp_rdy(rsp_rdy),
        .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err), .o_lcd_vld(lcd_vld),
        .i_io_sw(io_sw), .i_io_btn(io_btn), .o_io_ledr(io_ledr), .o_io_ledg(io_ledg),
        .o_io_lcd(io_lcd), .o_io_hex(io_hex)
    );

    always #5 clk = ~clk;

    // Reference model: memory is a byte array, registers are plain variables
    logic [7:0]  m_dmem [256];
    logic [31:0] m_ledr, m_ledg, m_lcd;
    logic [6:0]  m_hex [8];
    logic [3:0]  m_edge, m_btn_level;

    function automatic logic m_mapped(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (a[31:16] != 16'h0) return 1'b0;
        if (a >= 32'h2000 && a < 32'h2100) return 1'b1;
        return (w == 32'h7000 || w == 32'h7010 || w == 32'h7020 || w == 32'h7024 ||
                w == 32'h7030 || w == 32'h7800 || w == 32'h7810 || w == 32'h7814);
    endfunction

    function automatic logic m_err(input logic [31:0] a, input logic w, input logic [1:0] s);
        logic [31:0] wa;
        wa = {a[31:2], 2'b00};
        if (s == 2'd3) return 1'b1;
        if (s == 2'd1 && a[0]) return 1'b1;
        if (s == 2'd2 && a[1:0] != 2'b00) return 1'b1;
        if (!m_mapped(a)) return 1'b1;
        return w && (wa == 32'h7800 || wa == 32'h7810);
    endfunction

    function automatic logic [7:0] m_rd_byte(input logic [31:0] a);
        logic [31:0] w;
        int ln;
        ln = int'(a[1:0]);
        case ({a[31:2], 2'b00})
            32'h7000: w = m_ledr;
            32'h7010: w = m_ledg;
            32'h7020: w = {1'b0, m_hex[3], 1'b0, m_hex[2], 1'b0, m_hex[1], 1'b0, m_hex[0]};
            32'h7024: w = {1'b0, m_hex[7], 1'b0, m_hex[6], 1'b0, m_hex[5], 1'b0, m_hex[4]};
            32'h7030: w = m_lcd;
            32'h7800: w = io_sw;
            32'h7810: w = {28'h0, m_btn_level};
            32'h7814: w = {28'h0, m_edge};
            default:  return m_dmem[a[7:0]];
        endcase
        return w[8*ln +: 8];
    endfunction

    task automatic m_wr_byte(input logic [31:0] a, input logic [7:0] v);
        int ln;
        ln = int'(a[1:0]);
        case ({a[31:2], 2'b00})
            32'h7000: m_ledr[8*ln +: 8] = v;
            32'h7010: m_ledg[8*ln +: 8] = v;
            32'h7020: m_hex[ln] = v[6:0];
            32'h7024: m_hex[ln+4] = v[6:0];
            32'h7030: m_lcd[8*ln +: 8] = v;
            32'h7814: if (ln == 0) m_edge = m_edge & ~v[3:0];
            default:  m_dmem[a[7:0]] = v;
        endcase
    endtask

    function automatic logic [31:0] m_load(input logic [31:0] a, input logic [1:0] s, input logic u);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < (1 << s); i++) v[8*i +: 8] = m_rd_byte(a + 32'(i));
        if (s == 2'd0) return u ? {24'h0, v[7:0]} : {{24{v[7]}}, v[7:0]};
        if (s == 2'd1) return u ? {16'h0, v[15:0]} : {{16{v[15]}}, v[15:0]};
        return v;
    endfunction

    task automatic m_store(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
        for (int i = 0; i < (1 << s); i++) m_wr_byte(a + 32'(i), d[8*i +: 8]);
    endtask

    task automatic m_reset();
        m_ledr = '0; m_ledg = '0; m_lcd = '0; m_edge = '0;
        for (int k = 0; k < 8; k++) m_hex[k] = '0;
    endtask

    function automatic logic [55:0] m_hex_vec();
        logic [55:0] h;
        for (int k = 0; k < 8; k++) h[7*k +: 7] = m_hex[k];
        return h;
    endfunction

    // One request with rsp_rdy high; returns at the negedge where the response is shown
    task automatic xact(input logic [31:0] a, input logic w, input logic [1:0] s, input logic u,
                        input logic [31:0] d, output logic [31:0] rd, output logic e);
        int n;
        @(negedge clk);
        req_vld = 1'b1; req_addr = a; req_wren = w; req_size = s; req_uns = u; req_wdata = d;
        n = 0;
        while (!req_rdy && n < 50) begin @(negedge clk); n++; end
        @(posedge clk);
        #1 req_vld = 1'b0;
        @(negedge clk);
        n = 0;
        while (!rsp_vld && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (rsp_vld !== 1'b1) begin
            failures++;
            $display("FAIL xact_timeout addr=%h rsp_vld=%b required 1", a, rsp_vld);
        end
        rd = rsp_rdata; e = rsp_err;
    endtask

    task automatic do_reset();
        rst = 1'b1; req_vld = 1'b0; req_addr = '0; req_wren = 1'b0; req_size = 2'd0;
        req_uns = 1'b0; req_wdata = '0; rsp_rdy = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        m_reset();
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if ({rsp_vld, rsp_err, lcd_vld, req_rdy} !== 4'b0001 || rsp_rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_ctrl vld/err/lcd/rdy=%b rdata=%h required 0001 0", {rsp_vld, rsp_err, lcd_vld, req_rdy}, rsp_rdata);
        end
        checks++;
        if (io_ledr !== 32'h0 || io_ledg !== 32'h0 || io_lcd !== 32'h0 || io_hex !== 56'h0) begin
            failures++;
            $display("FAIL reset_io ledr=%h ledg=%h lcd=%h hex=%h required all 0", io_ledr, io_ledg, io_lcd, io_hex);
        end
    endtask

    task automatic test_dmem_sizes();
        logic [31:0] rd; logic e;
        xact(32'h2004, 1'b1, 2'd2, 1'b0, 32'hDEADBEEF, rd, e);
        m_store(32'h2004, 2'd2, 32'hDEADBEEF);
        checks++;
        if (rd !== 32'h0 || e !== 1'b0) begin failures++; $display("FAIL sw_rsp rdata=%h err=%b required 0 0", rd, e); end
        xact(32'h2007, 1'b0, 2'd0, 1'b0, 32'h0, rd, e);
        checks++;
        if (rd !== 32'hFFFFFFDE || e !== 1'b0) begin failures++; $display("FAIL lb rdata=%h err=%b required ffffffde 0", rd, e); end
        xact(32'h2007, 1'b0, 2'd0, 1'b1, 32'h0, rd, e);
        checks++;
        if (rd !== 32'h000000DE) begin failures++; $display("FAIL lbu rdata=%h required 000000de", rd); end
        xact(32'h2006, 1'b0, 2'd1, 1'b0, 32'h0, rd, e);
        checks++;
        if (rd !== 32'hFFFFDEAD) begin failures++; $display("FAIL lh rdata=%h required ffffdead", rd); end
    endtask

    task automatic test_led_lanes();
        logic [31:0] rd; logic e;
        xact(32'h7001, 1'b1, 2'd0, 1'b0, 32'h0000005A, rd, e);
        m_store(32'h7001, 2'd0, 32'h5A);
        checks++;
        if (io_ledr !== 32'h00005A00) begin failures++; $display("FAIL sb_ledr ledr=%h required 00005a00", io_ledr); end
        xact(32'h7002, 1'b1, 2'd1, 1'b0, 32'h00001234, rd, e);
        m_store(32'h7002, 2'd1, 32'h1234);
        checks++;
        if (io_ledr !== 32'h12345A00) begin failures++; $display("FAIL sh_ledr ledr=%h required 12345a00", io_ledr); end
        xact(32'h7000, 1'b0, 2'd2, 1'b0, 32'h0, rd, e);
        checks++;
        if (rd !== 32'h12345A00 || e !== 1'b0) begin failures++; $display("FAIL lw_ledr rdata=%h err=%b required 12345a00 0", rd, e); end
    endtask

    task automatic test_errors();
        logic [31:0] addrs [6] = '{32'h2001, 32'h7002, 32'h2004, 32'h9000, 32'h2005, 32'h7800};
        logic        wrs   [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [1:0]  sizes [6] = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd1, 2'd2};
        logic [31:0] rd; logic e;
        for (int i = 0; i < 6; i++) begin
            xact(addrs[i], wrs[i], sizes[i], 1'b0, 32'hFFFF_FFFF, rd, e);
            checks++;
            if (e !== 1'b1 || rd !== 32'h0) begin
                failures++;
                $display("FAIL err_case%0d addr=%h err=%b rdata=%h required 1 0", i, addrs[i], e, rd);
            end
        end
        checks++;
        if (io_ledr !== 32'h12345A00) begin failures++; $display("FAIL err_noledr ledr=%h required 12345a00", io_ledr); end
        xact(32'h2004, 1'b0, 2'd2, 1'b0, 32'h0, rd, e);
        checks++;
        if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL err_nodmem rdata=%h required deadbeef", rd); end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd0;
        @(negedge clk);
        rsp_rdy = 1'b0; req_vld = 1'b1; req_addr = 32'h2004; req_wren = 1'b0; req_size = 2'd2; req_uns = 1'b0;
        @(posedge clk);
        #1 req_vld = 1'b0;
        @(negedge clk);
        rd0 = rsp_rdata;
        checks++;
        if (rsp_vld !== 1'b1 || rd0 !== 32'hDEADBEEF) begin
            failures++; $display("FAIL bp_first vld=%b rdata=%h required 1 deadbeef", rsp_vld, rd0);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_vld !== 1'b1 || rsp_rdata !== rd0 || req_rdy !== 1'b0) begin
                failures++; $display("FAIL bp_hold%0d vld=%b rdata=%h rdy=%b required 1 %h 0", i, rsp_vld, rsp_rdata, req_rdy, rd0);
            end
        end
        req_vld = 1'b1; req_addr = 32'h7000; rsp_rdy = 1'b1;
        #1;
        checks++;
        if (req_rdy !== 1'b1) begin failures++; $display("FAIL bp_release rdy=%b required 1", req_rdy); end
        @(posedge clk);
        #1 req_vld = 1'b0;
        @(negedge clk);
        checks++;
        if (rsp_vld !== 1'b1 || rsp_rdata !== 32'h12345A00) begin
            failures++; $display("FAIL bp_next vld=%b rdata=%h required 1 12345a00", rsp_vld, rsp_rdata);
        end
    endtask

    task automatic test_buttons();
        logic [31:0] rd; logic e;
        @(negedge clk); io_btn = 4'b0100;
        repeat (4) @(negedge clk);
        io_btn = 4'b0000;
        repeat (4) @(negedge clk);
        xact(32'h7814, 1'b0, 2'd2, 1'b0, 32'h0, rd, e);
        checks++;
        if (rd !== 32'h4) begin failures++; $display("FAIL btn_edge_set rdata=%h required 4", rd); end
        xact(32'h7814, 1'b1, 2'd0, 1'b0, 32'h04, rd, e);
        xact(32'h7814, 1'b0, 2'd2, 1'b0, 32'h0, rd, e);
        checks++;
        if (rd !== 32'h0) begin failures++; $display("FAIL btn_edge_clr rdata=%h required 0", rd); end
        // edge reaches the sticky bit on the third clock edge after the pin rises
        @(negedge clk); io_btn = 4'b0100;
        @(negedge clk);
        @(negedge clk);
        req_vld = 1'b1; req_addr = 32'h7814; req_wren = 1'b1; req_size = 2'd0; req_wdata = 32'h04;
        @(posedge clk);
        #1 req_vld = 1'b0;
        xact(32'h7814, 1'b0, 2'd2, 1'b0, 32'h0, rd, e);
        checks++;
        if (rd !== 32'h4) begin failures++; $display("FAIL btn_set_wins rdata=%h required 4", rd); end
        xact(32'h7810, 1'b0, 2'd2, 1'b0, 32'h0, rd, e);
        checks++;
        if (rd !== 32'h4) begin failures++; $display("FAIL btn_level rdata=%h required 4", rd); end
        io_btn = 4'b0000;
        repeat (4) @(negedge clk);
        xact(32'h7814, 1'b1, 2'd2, 1'b0, 32'hFFFF_FFFF, rd, e);
    endtask

    task automatic test_lcd_and_reset();
        logic [31:0] rd; logic e;
        xact(32'h7030, 1'b1, 2'd2, 1'b0, 32'h41, rd, e);
        checks++;
        if (lcd_vld !== 1'b1 || io_lcd !== 32'h41) begin
            failures++; $display("FAIL lcd_pulse vld=%b lcd=%h required 1 41", lcd_vld, io_lcd);
        end
        @(negedge clk);
        checks++;
        if (lcd_vld !== 1'b0 || io_lcd !== 32'h41) begin
            failures++; $display("FAIL lcd_pulse_end vld=%b lcd=%h required 0 41", lcd_vld, io_lcd);
        end
        rsp_rdy = 1'b0; req_vld = 1'b1; req_addr = 32'h7000; req_wren = 1'b0; req_size = 2'd2;
        @(posedge clk);
        #1 req_vld = 1'b0;
        @(negedge clk);
        checks++;
        if (rsp_vld !== 1'b1) begin failures++; $display("FAIL rst_pre vld=%b required 1", rsp_vld); end
        rst = 1'b1;
        #1;
        checks++;
        if (rsp_vld !== 1'b0 || rsp_rdata !== 32'h0 || io_ledr !== 32'h0 || io_ledg !== 32'h0 ||
            io_lcd !== 32'h0 || io_hex !== 56'h0 || lcd_vld !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid vld=%b rdata=%h ledr=%h lcd=%h hex=%h required all 0", rsp_vld, rsp_rdata, io_ledr, io_lcd, io_hex);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0; rsp_rdy = 1'b1;
        m_reset();
        @(negedge clk);
        checks++;
        if (req_rdy !== 1'b1 || rsp_vld !== 1'b0) begin
            failures++; $display("FAIL rst_after rdy=%b vld=%b required 1 0", req_rdy, rsp_vld);
        end
    endtask

    task automatic test_random();
        logic [31:0] plist [9] = '{32'h7000, 32'h7010, 32'h7020, 32'h7024, 32'h7030,
                                   32'h7800, 32'h7810, 32'h7814, 32'h7004};
        logic [31:0] a, d, rd, exp_rd;
        logic [1:0]  s;
        logic        w, u, e, exp_e;
        io_sw = $urandom;
        @(negedge clk); io_btn = 4'b1011;
        repeat (6) @(negedge clk);
        m_btn_level = 4'b1011;
        m_edge = m_edge | 4'b1011;
        for (int i = 0; i < 64; i++) begin
            d = $urandom;
            xact(32'h2000 + 32'(4*i), 1'b1, 2'd2, 1'b0, d, rd, e);
            m_store(32'h2000 + 32'(4*i), 2'd2, d);
        end
        for (int i = 0; i < 250; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: a = 32'h2000 + 32'($urandom_range(0, 255));
                4, 5, 6, 7: a = plist[$urandom_range(0, 8)] + 32'($urandom_range(0, 3));
                8:          a = 32'h9000 + 32'($urandom_range(0, 3));
                default:    a = ($urandom_range(0, 1) == 0) ? 32'h0001_2000 : 32'h2100 + 32'($urandom_range(0, 7));
            endcase
            s = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            if (s == 2'd1 && $urandom_range(0, 1) == 1) a[0] = 1'b0;
            if (s == 2'd2 && $urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            w = 1'($urandom_range(0, 1));
            u = 1'($urandom_range(0, 1));
            d = $urandom;
            exp_e  = m_err(a, w, s);
            exp_rd = (exp_e || w) ? 32'h0 : m_load(a, s, u);
            xact(a, w, s, u, d, rd, e);
            if (!exp_e && w) m_store(a, s, d);
            checks++;
            if (rd !== exp_rd || e !== exp_e) begin
                failures++;
                $display("FAIL rand%0d addr=%h wr=%b size=%0d rdata=%h err=%b required %h %b", i, a, w, s, rd, e, exp_rd, exp_e);
            end
            checks++;
            if (io_ledr !== m_ledr || io_ledg !== m_ledg || io_lcd !== m_lcd || io_hex !== m_hex_vec()) begin
                failures++;
                $display("FAIL rand_io%0d ledr=%h ledg=%h lcd=%h hex=%h required %h %h %h %h", i,
                         io_ledr, io_ledg, io_lcd, io_hex, m_ledr, m_ledg, m_lcd, m_hex_vec());
            end
        end
    endtask

    initial begin
        io_sw = 32'h0; io_btn = 4'h0; m_btn_level = 4'h0;
        test_reset();
        test_dmem_sizes();
        test_led_lanes();
        test_errors();
        test_backpressure();
        test_buttons();
        test_lcd_and_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/lsu_mmio_v2.md
Name: lsu_mmio_v2

Overview:
- Parametrised second-generation load/store unit for the RV32I core: data memory plus memory-mapped LEDs, 7-seg, LCD, switches and buttons.
- Adds to the first generation: a valid/ready request/response handshake, and RISC-V load/store size handling (LB/LH/LW/LBU/LHU/SB/SH/SW) with lane alignment and extension.
- Also adds misalignment/unmapped error reporting and synchronised button edge capture with write-1-to-clear.
- Sits between the core's MEM stage and the board I/O.

Parameters:
- DMEM_BASE, 32'h0000_2000, byte base of data memory; must be aligned to DMEM_DEPTH*4.
- DMEM_DEPTH, 64, data memory depth in 32-bit words; power of 2, 16..4096.
- LEDR_W, 32, red LED register width, 1..32.
- LEDG_W, 32, green LED register width, 1..32.
- SW_W, 32, switch input width, 1..32.
- BTN_W, 4, button input width, 1..32.
- NUM_HEX, 8, number of 7-seg digits, 1..8.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous reset, active-high.
- i_req_vld  in  1  request valid.
- o_req_rdy  out  1  request ready.
- i_req_addr  in  32  byte address.
- i_req_wren  in  1  1 = store, 0 = load.
- i_req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- i_req_unsigned  in  1  zero-extend load (LBU/LHU); ignored for word loads and stores.
- i_req_wdata  in  32  store data, LSB-aligned.
- o_rsp_vld  out  1  response valid.
- i_rsp_rdy  in  1  response accepted.
- o_rsp_rdata  out  32  load result, extended; 0 for stores and errors.
- o_rsp_err  out  1  misaligned, illegal size or unmapped address.
- o_lcd_vld  out  1  one-cycle pulse: lcd register updated.
- i_io_sw  in  SW_W  switches.
- i_io_btn  in  BTN_W  buttons, asynchronous.
- o_io_ledr  out  LEDR_W  red LEDs.
- o_io_ledg  out  LEDG_W  green LEDs.
- o_io_lcd  out  32  LCD register.
- o_io_hex  out  NUM_HEX*7  digit k at bits [7k+6:7k].

Behaviour:
- Clock and reset: one clock, i_clk. i_rst is asynchronous and active-high.
- Address map: each region matches only when addr[31:16] == 0.
  - DMEM: [DMEM_BASE, DMEM_BASE + 4*DMEM_DEPTH).
  - LEDR 0x7000, LEDG 0x7010, SEG7_LO 0x7020, SEG7_HI 0x7024, LCD 0x7030: read/write.
  - SW 0x7800, BTN 0x7810: read-only.
  - BTN_EDGE 0x7814: read, write-1-to-clear.
  - Peripheral decode uses addr[15:2].
- Handshake: o_req_rdy = !o_rsp_vld || i_rsp_rdy. A request is accepted on a clock edge where i_req_vld && o_req_rdy.
  - Response appears the cycle after acceptance: o_rsp_vld = 1 with rdata and err.
  - Response is held stable until i_rsp_rdy. Back-to-back throughput is 1 request per cycle.
  - Two-state FSM: IDLE → RESP on accept. RESP → IDLE on i_rsp_rdy with no new accept. RESP stays RESP on i_rsp_rdy with a new accept.
- Error: err = 1 for any of:
  - size 11;
  - half access with addr[0] = 1;
  - word access with addr[1:0] != 0;
  - unmapped address;
  - store to SW or BTN.
  - On error: no state change, rdata = 0.
- Stores:
  - Lane mask from size and addr[1:0]: byte = 1 lane, half = lanes {1,0} or {3,2}, word = all lanes.
  - Data is replicated across lanes: byte replicated 4x, half 2x.
  - Masked merge into the target; commits at the accept edge.
  - Registers narrower than 32 bits keep the low bits only.
  - SEG7 keeps bits [6:0] of each byte lane. Lanes for digits ≥ NUM_HEX are dropped.
- Loads:
  - The 32-bit word is sampled at the accept edge, shifted right by 8*addr[1:0], then sign- or zero-extended per size and i_req_unsigned.
  - Narrow registers read zero-padded. Absent hex lanes read 0.
  - A read issued the cycle after a write to the same location returns the new value.
- Buttons:
  - 2-flop synchroniser on i_io_btn. BTN reads the synchronised level.
  - A rising edge of a synchronised bit sets the sticky bit in BTN_EDGE.
  - An accepted store to BTN_EDGE clears the bits written with 1 within the masked lanes.
  - Same-cycle set and clear on one bit: set wins.
- o_lcd_vld: registered. 1 for exactly one cycle after an accepted non-error store to LCD, aligned with o_io_lcd updating.
- Reset:
  - All registers, sync flops and BTN_EDGE go to 0. FSM goes to IDLE; o_rsp_vld = 0, o_rsp_rdata = 0, o_rsp_err = 0, o_lcd_vld = 0.
  - All I/O outputs are 0. o_req_rdy = 1 once reset is released.
  - DMEM is not reset and stays inferrable as block RAM.
  - Reset asserted during RESP drops the pending response.

Test Plan:
- SW 0x2004 = 0xDEADBEEF, then LB 0x2007 → rdata 0xFFFFFFDE, err 0. LBU 0x2007 → 0x000000DE. LH 0x2006 → 0xFFFFDEAD.
- SB 0x7001 data 0x5A with LEDR = 0 → ledr = 0x00005A00. SH 0x7002 0x1234 → 0x12345A00. LW 0x7000 returns the same.
- LH 0x2001, SW 0x7002, size 11, and LW 0x9000 → each err 1, rdata 0, no register or DMEM change.
- Hold i_rsp_rdy = 0 for 3 cycles after a load → o_rsp_vld and data stable, o_req_rdy = 0. Release → next request accepted the same cycle.
- Pulse btn[2] for 4 cycles → BTN_EDGE reads 0x4. SB 0x7814 data 0x04 → reads 0. Clear on the same cycle as a new edge → bit stays 1.
- SW to LCD 0x7030 = 0x41 → o_lcd_vld one-cycle pulse with o_io_lcd = 0x41. Assert i_rst mid-RESP → o_rsp_vld 0 immediately, all I/O outputs 0.
